// File: rtl/player_input_conditioner.sv
// Player button conditioning: synchronize and debounce left/right/attack buttons,
// then turn accepted attack presses into fixed-length pulses with a cooldown.
module player_input_conditioner #(
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned ATTACK_HOLD     = 6,
  parameter int unsigned ATTACK_COOLDOWN = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [2:0] btn_n,
  input  logic       enable,
  output logic       left,
  output logic       right,
  output logic       attack,
  output logic [1:0] attack_phase
);

  localparam int unsigned DbW  = 4;
  localparam int unsigned PhW  = 6;
  localparam int unsigned BtnN = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2
  } phase_e;

  logic [BtnN-1:0]          sync1_q, sync2_q;
  logic [BtnN-1:0]          db_q, db_d;
  logic [BtnN-1:0][DbW-1:0] dbcnt_q, dbcnt_d;
  logic                     atk_edge;
  logic                     left_q, right_q, attack_q;
  logic [PhW-1:0]           phase_cnt_q;
  phase_e                   state_q;

  // Buttons are inverted to active-high before the two-flop synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~btn_n;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    db_d    = db_q;
    dbcnt_d = dbcnt_q;
    if (frame_tick) begin
      for (int i = 0; i < int'(BtnN); i++) begin
        if (sync2_q[i] == db_q[i]) begin
          dbcnt_d[i] = '0;
        end else if (dbcnt_q[i] + DbW'(1) == DbW'(DEBOUNCE_FRAMES)) begin
          db_d[i]    = ~db_q[i];
          dbcnt_d[i] = '0;
        end else begin
          dbcnt_d[i] = dbcnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q    <= '0;
      dbcnt_q <= '0;
    end else begin
      db_q    <= db_d;
      dbcnt_q <= dbcnt_d;
    end
  end

  // Single-cycle flag: debounced attack level rising on this frame tick.
  assign atk_edge = frame_tick & ~db_q[0] & db_d[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      left_q  <= db_q[2] & ~db_q[1] & enable;
      right_q <= db_q[1] & ~db_q[2] & enable;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      attack_q    <= 1'b0;
    end else if (!enable) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      attack_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (atk_edge) begin
            state_q     <= ACTIVE;
            phase_cnt_q <= '0;
            attack_q    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (frame_tick) begin
            if (phase_cnt_q == PhW'(ATTACK_HOLD - 1)) begin
              state_q     <= (ATTACK_COOLDOWN == 0) ? IDLE : COOLDOWN;
              phase_cnt_q <= '0;
              attack_q    <= 1'b0;
            end else begin
              phase_cnt_q <= phase_cnt_q + PhW'(1);
            end
          end
        end
        COOLDOWN: begin
          // Edges seen here are dropped; only a fresh press after IDLE re-arms.
          if (frame_tick) begin
            if (phase_cnt_q == PhW'(ATTACK_COOLDOWN - 1)) begin
              state_q     <= IDLE;
              phase_cnt_q <= '0;
            end else begin
              phase_cnt_q <= phase_cnt_q + PhW'(1);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          phase_cnt_q <= '0;
          attack_q    <= 1'b0;
        end
      endcase
    end
  end

  assign left         = left_q;
  assign right        = right_q;
  assign attack       = attack_q;
  assign attack_phase = state_q;

endmodule

// File: doc/player_input_conditioner.md
PLAYER_INPUT_CONDITIONER -- requirements
Module: player_input_conditioner

Interface
REQ-001: Parameter DEBOUNCE_FRAMES, default 3, SHALL set the consecutive frame_tick samples needed to accept a button level change (range 1..15).
REQ-002: Parameter ATTACK_HOLD, default 6, SHALL set the frame_ticks that the attack output stays high per accepted press (range 1..63).
REQ-003: Parameter ATTACK_COOLDOWN, default 12, SHALL set the frame_ticks after ATTACK_HOLD during which new presses are ignored (range 0..63).
REQ-004: clk  input  1  system clock; the only clock in the block.
REQ-005: rst  input  1  reset; asynchronous and active-high.
REQ-006: frame_tick  input  1  one-clk strobe per video frame; all debounce and attack timing advances only on cycles with frame_tick=1.
REQ-007: btn_n  input  3  raw asynchronous buttons, active-low; [2]=left, [1]=right, [0]=attack.
REQ-008: enable  input  1  game-running qualifier; 0 forces all control outputs low.
REQ-009: left  output  1  registered, debounced move-left request.
REQ-010: right  output  1  registered, debounced move-right request.
REQ-011: attack  output  1  registered attack request, high for exactly ATTACK_HOLD frame_ticks per accepted press.
REQ-012: attack_phase  output  2  FSM state: 0=IDLE, 1=ACTIVE, 2=COOLDOWN; 3 is never driven.

Function
REQ-013: Each btn_n bit SHALL be inverted and passed through a 2-flop synchronizer clocked every clk, irrespective of frame_tick.
REQ-014: Each button SHALL have a debounced level db and a counter; on frame_tick, if the synchronized level equals db, the counter SHALL clear to 0.
REQ-015: On frame_tick with synchronized level different from db, the counter SHALL increment; when it would reach DEBOUNCE_FRAMES, db SHALL toggle and the counter SHALL clear.
REQ-016: Latency: a clean raw press SHALL update db on the DEBOUNCE_FRAMES-th frame_tick occurring at least 2 clk after the raw edge.
REQ-017: left SHALL equal db_left AND NOT db_right AND enable, registered one clk after db; right is symmetric; simultaneous left+right SHALL yield left=right=0.
REQ-018: An attack edge SHALL be flagged only on a frame_tick where db_attack toggles 0->1; the flag lives for that single cycle.
REQ-019: IDLE -> ACTIVE on a flagged attack edge with enable=1; phase counter loads 0.
REQ-020: ACTIVE: attack=1; counter increments per frame_tick; after ATTACK_HOLD frame_ticks SHALL go to COOLDOWN (or IDLE if ATTACK_COOLDOWN=0), counter cleared.
REQ-021: COOLDOWN: attack=0; after ATTACK_COOLDOWN frame_ticks SHALL go to IDLE.
REQ-022: Attack edges arriving in ACTIVE or COOLDOWN SHALL be discarded, not queued.
REQ-023: A button held continuously through COOLDOWN SHALL NOT retrigger; re-arming requires release and new debounced press.
REQ-024: enable=0 SHALL force FSM to IDLE, clear the phase counter, and drive left/right/attack low on the next clk; debouncers keep running.
REQ-025: Counters SHALL be sized for the parameter maxima and SHALL never wrap in normal operation.
REQ-026: With frame_tick held 0, all outputs and states SHALL hold their values.

Reset
REQ-027: rst=1 SHALL immediately (asynchronously) clear synchronizers, db levels (released), debounce counters, phase counter, and FSM to IDLE.
REQ-028: Output reset values: left=0, right=0, attack=0, attack_phase=0.
REQ-029: After rst deasserts, a button held low throughout SHALL register as a new press after DEBOUNCE_FRAMES frame_ticks.

Verification
REQ-030: Bounce: defaults, btn_n[0] low for 2 frame_ticks then high -> attack stays 0, attack_phase stays 0.
REQ-031: Clean press: btn_n[0] held low -> attack=1 starting on the 3rd frame_tick, high exactly 6 frame_ticks, attack_phase=2 for 12 frame_ticks, then 0; held button gives no second pulse.
REQ-032: Cooldown press: release and re-press during COOLDOWN -> ignored; re-press after IDLE -> new 6-frame attack.
REQ-033: Conflict: btn_n[2] and btn_n[1] both held low -> left=0, right=0; release right -> left=1 after 3 frame_ticks.
REQ-034: enable drop: enable=0 during ACTIVE -> attack=0, attack_phase=0 one clk later; enable=1 with button still held -> no attack until release and re-press.
REQ-035: Reset mid-attack: rst pulse during ACTIVE, no clk edge -> attack=0, attack_phase=0 while rst is high.
